pipe_generator: RTL and testbench



---
 rtl/flappy_pkg.sv | 31 +++
 rtl/pipe_generator_if.sv | 34 +++
 rtl/pipe_generator_lfsr8.sv | 29 ++
 rtl/pipe_generator.sv | 103 ++++++++++
 tb/tb_pipe_generator.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy LED-field pipeline.
//   column_t      : one 16-row column, bit i = row i, row 0 = top, 1 = lit
//   pipe_state_e  : pipe generator FSM states
//   LFSR_TAPS     : feedback tap mask for the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   pipe_mask()   : solid column with a zeroed opening of gap_h rows at top
package flappy_pkg;

    localparam int unsigned ROWS = 16;
    localparam int unsigned COLS = 16;

    typedef logic [15:0] column_t;

    typedef enum logic {
        S_SPACE,
        S_PIPE
    } pipe_state_e;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic column_t pipe_mask(input logic [3:0] top, input int unsigned gap_h);
        column_t m;
        m = '1;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if ((i >= int'(top)) && (i < int'(top) + gap_h)) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_generator_if.sv
// Handshake bundle between the game-speed logic, the pipe generator and
// shifterRight.
//   clkP      : one-clk game-speed tick
//   gameover  : level, freezes generation while high
//   newPipe   : column to be inserted on the next accepted tick
//   pipeStart : one-clk pulse when newPipe becomes the first column of a pipe
//   lfsrOut   : current LFSR state
// master drives clkP/gameover, slave (the generator) drives the rest.
interface pipe_generator_if;
    import flappy_pkg::*;

    logic        clkP;
    logic        gameover;
    column_t     newPipe;
    logic        pipeStart;
    logic [7:0]  lfsrOut;

    modport master (
        output clkP,
        output gameover,
        input  newPipe,
        input  pipeStart,
        input  lfsrOut
    );

    modport slave (
        input  clkP,
        input  gameover,
        output newPipe,
        output pipeStart,
        output lfsrOut
    );

endinterface

// File: rtl/pipe_generator_lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left by one on each enabled clock.
//   clk   : system clock
//   reset : synchronous active-high, loads SEED
//   en    : advance enable
//   q     : current state
module lfsr8
    import flappy_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_generator.sv
// Pipe column generator feeding shifterRight. Emits PIPE_W-wide pipes with a
// GAP_H-row opening at an LFSR-chosen height, separated by SPACE_W empty
// columns. newPipe always holds the column to be consumed on the next tick.
//   clk   : system clock
//   reset : synchronous active-high
//   bus   : pipe_generator_if slave (clkP, gameover in; newPipe, pipeStart,
//           lfsrOut out)
module pipe_generator
    import flappy_pkg::*;
#(
    parameter int unsigned GAP_H   = 4,
    parameter int unsigned PIPE_W  = 2,
    parameter int unsigned SPACE_W = 4,
    parameter int unsigned MARGIN  = 1,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    pipe_generator_if.slave bus
);

    localparam int unsigned RANGE   = ROWS - GAP_H - 2 * MARGIN + 1;
    localparam int unsigned CNT_MAX = (PIPE_W > SPACE_W) ? PIPE_W : SPACE_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACE_W - 1);
    localparam logic [CNT_W-1:0] PIPE_LAST  = CNT_W'(PIPE_W - 1);

    logic             w_tick;
    logic [7:0]       w_lfsr;
    logic [4:0]       w_nib;
    logic [3:0]       w_r;
    logic [3:0]       w_gap_new;

    pipe_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gapTop;
    column_t          r_newPipe;
    logic             r_pipeStart;

    assign w_tick = bus.clkP & ~bus.gameover;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick),
        .q     (w_lfsr)
    );

    // Fold the low nibble into [0, RANGE); one subtraction suffices since
    // RANGE >= 8. Taken from the pre-shift LFSR value.
    assign w_nib     = {1'b0, w_lfsr[3:0]};
    assign w_r       = (w_nib >= 5'(RANGE)) ? 4'(w_nib - 5'(RANGE)) : w_nib[3:0];
    assign w_gap_new = 4'(MARGIN) + w_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SPACE;
            r_cnt       <= '0;
            r_gapTop    <= 4'(MARGIN);
            r_newPipe   <= '0;
            r_pipeStart <= 1'b0;
        end else begin
            r_pipeStart <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_SPACE: begin
                        if (r_cnt == SPACE_LAST) begin
                            r_state     <= S_PIPE;
                            r_cnt       <= '0;
                            r_gapTop    <= w_gap_new;
                            r_newPipe   <= pipe_mask(w_gap_new, GAP_H);
                            r_pipeStart <= 1'b1;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_newPipe <= '0;
                        end
                    end
                    S_PIPE: begin
                        if (r_cnt == PIPE_LAST) begin
                            r_state   <= S_SPACE;
                            r_cnt     <= '0;
                            r_newPipe <= '0;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_newPipe <= pipe_mask(r_gapTop, GAP_H);
                        end
                    end
                    default: begin
                        r_state   <= S_SPACE;
                        r_cnt     <= '0;
                        r_newPipe <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.newPipe   = r_newPipe;
    assign bus.pipeStart = r_pipeStart;
    assign bus.lfsrOut   = w_lfsr;

endmodule

// File: tb/tb_pipe_generator.sv
// Directed + randomized bench for pipe_generator against a column-index
// reference model (position within a SPACE_W+PIPE_W column period).
module tb_pipe_generator;

    localparam int unsigned GAP_H   = 4;
    localparam int unsigned PIPE_W  = 2;
    localparam int unsigned SPACE_W = 4;
    localparam int unsigned MARGIN  = 1;
    localparam logic [7:0]  SEED    = 8'hA5;
    localparam int unsigned RANGE   = 16 - GAP_H - 2 * MARGIN + 1;
    localparam int unsigned PERIOD  = SPACE_W + PIPE_W;

    logic clk = 1'b0;
    logic reset;

    pipe_generator_if bus();

    pipe_generator #(
        .GAP_H   (GAP_H),
        .PIPE_W  (PIPE_W),
        .SPACE_W (SPACE_W),
        .MARGIN  (MARGIN),
        .SEED    (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: m_idx is the index within the column period of the
    // column currently presented; indices >= SPACE_W are pipe columns.
    int unsigned m_idx;
    logic [7:0]  m_lfsr;
    logic [7:0]  m_pre;
    int unsigned m_gap;
    logic [15:0] m_np;
    logic        m_ps;

    function automatic logic [15:0] model_mask(input int unsigned gap);
        logic [31:0] ones;
        ones = (32'd1 << GAP_H) - 32'd1;
        return ~(16'(ones << gap));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic g, input logic r);
        logic tick;
        @(negedge clk);
        bus.clkP     = p;
        bus.gameover = g;
        reset        = r;
        @(posedge clk);
        tick = 1'b0;
        if (r) begin
            m_idx  = 0;
            m_lfsr = SEED;
            m_gap  = MARGIN;
            m_np   = '0;
            m_ps   = 1'b0;
        end else if (p && !g) begin
            tick   = 1'b1;
            m_pre  = m_lfsr;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_idx  = (m_idx + 1) % PERIOD;
            m_ps   = (m_idx == SPACE_W);
            if (m_ps) m_gap = MARGIN + (int'(m_pre) % 16) % RANGE;
            m_np   = (m_idx >= SPACE_W) ? model_mask(m_gap) : 16'h0000;
        end else begin
            m_ps = 1'b0;
        end
        #1;
        chk("newPipe",   32'(bus.newPipe),   32'(m_np));
        chk("pipeStart", 32'(bus.pipeStart), 32'(m_ps));
        chk("lfsrOut",   32'(bus.lfsrOut),   32'(m_lfsr));
        if (m_idx >= SPACE_W) begin
            chk("gap_rows", 32'($countones(~bus.newPipe)), GAP_H);
            chk("row0_lit",  32'(bus.newPipe[0]),  32'd1);
            chk("row15_lit", 32'(bus.newPipe[15]), 32'd1);
        end
        if (tick && m_ps) begin
            case (m_pre[3:0])
                4'd13: chk("mask_nib13", 32'(bus.newPipe), 32'h0000FF87);
                4'd5:  chk("mask_nib5",  32'(bus.newPipe), 32'h0000FC3F);
                4'd15: chk("mask_nib15", 32'(bus.newPipe), 32'h0000FE1F);
                default: ;
            endcase
        end
    endtask

    initial begin
        int unsigned ticks;
        int unsigned cycles;
        logic        rp;
        logic        rg;

        bus.clkP     = 1'b0;
        bus.gameover = 1'b0;
        reset        = 1'b1;
        m_idx  = 0;
        m_lfsr = SEED;
        m_pre  = SEED;
        m_gap  = MARGIN;
        m_np   = '0;
        m_ps   = 1'b0;

        // Reset, then idle without ticks
        step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("reset_lfsr", 32'(bus.lfsrOut), 32'h000000A5);
        chk("reset_col",  32'(bus.newPipe), 32'h00000000);

        // Single-cycle ticks spaced 3 clk apart through one full period
        repeat (PERIOD) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end

        // Enter a pipe, then freeze with gameover while clkP keeps pulsing
        repeat (SPACE_W) step(1'b1, 1'b0, 1'b0);
        chk("freeze_entry_start", 32'(bus.pipeStart), 32'd1);
        repeat (8) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("resume_second_col", 32'(bus.newPipe), 32'(model_mask(m_gap)));
        step(1'b1, 1'b0, 1'b0);

        // Reset while presenting the first pipe column
        repeat (SPACE_W) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("midpipe_reset_col",  32'(bus.newPipe), 32'h00000000);
        chk("midpipe_reset_lfsr", 32'(bus.lfsrOut), 32'h000000A5);
        repeat (SPACE_W - 1) step(1'b1, 1'b0, 1'b0);
        chk("after_reset_no_pipe", 32'(bus.newPipe), 32'h00000000);
        step(1'b1, 1'b0, 1'b0);
        chk("after_reset_pipe_start", 32'(bus.pipeStart), 32'd1);

        // Randomized ticks, back-to-back clkP and occasional gameover
        ticks  = 0;
        cycles = 0;
        while (ticks < 200 && cycles < 4000) begin
            rp = 1'($urandom_range(0, 1));
            rg = ($urandom_range(0, 9) == 0);
            step(rp, rg, 1'b0);
            if (rp && !rg) ticks++;
            cycles++;
        end
        chk("tick_budget", 32'(ticks >= 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
